tick_generator: RTL and testbench

Parametrised multi-channel tick generator; the next generation of the single-purpose fixed-rate clock divider. It produces NUM_CH independent single-cycle enable pulses ("ticks"), each dividing the system clock by a runtime-programmable divisor. It sits at the top of the timing tree and feeds the counter, display-multiplex, blink and adjust logic as clock enables; it never drives clock pins. It adds phase realignment, a global pause and an optional 50%-duty square output per channel.

---
 rtl/tick_gen_pkg.sv | 16 +
 rtl/tick_channel.sv | 74 +++++++
 rtl/tick_generator.sv | 48 ++++
 tb/tb_tick_generator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: default widths, standard divisors
// for a 100 MHz system clock and the conventional channel assignment.
package tick_gen_pkg;

    localparam int          TG_CNT_W       = 27;
    localparam int unsigned DIV_1HZ        = 32'd100000000;
    localparam int unsigned DIV_2HZ        = 32'd50000000;
    localparam int unsigned DIV_300HZ      = 32'd333333;
    localparam int unsigned TG_DEFAULT_DIV = DIV_1HZ;

    localparam int CH_ADJ   = 0;
    localparam int CH_COUNT = 1;
    localparam int CH_DISP  = 2;
    localparam int CH_BLINK = 3;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: programmable divisor, counter and registered tick pulse.
// With TICK_GEN_SQUARE_EN defined it also carries a 50%-duty square output.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W       = TG_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(TG_DEFAULT_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
`ifdef TICK_GEN_SQUARE_EN
    output logic             sq,
`endif
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             at_term;

    assign active  = en && (div != '0);
    assign at_term = (cnt == div - ONE);

    // A write reloads the divisor and restarts the phase; sync_clr only restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= DEFAULT_DIV;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            div  <= load_div;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (sync_clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (div == '0) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            tick <= 1'b0;
        end else if (at_term) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    // Toggles on the same edge that raises tick, so the period is 2*div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq <= 1'b0;
        end else if (load || sync_clr) begin
            sq <= 1'b0;
        end else if (active && at_term) begin
            sq <= ~sq;
        end
    end
`else
    logic unused_active;
    assign unused_active = active;
`endif

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator: NUM_CH independent clock-enable pulses with
// runtime divisors, global pause and phase realign. Optional square outputs
// are enabled by defining TICK_GEN_SQUARE_EN.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = TG_CNT_W,
    parameter int unsigned DEFAULT_DIV = TG_DEFAULT_DIV,
    localparam int         WR_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [WR_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
`ifdef TICK_GEN_SQUARE_EN
    output logic [NUM_CH-1:0] sq,
`endif
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] load;

    // Indices at or above NUM_CH match no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = wr_en && (wr_ch == WR_W'(i));

        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .sync_clr (sync_clr),
            .load     (load[i]),
            .load_div (wr_div),
`ifdef TICK_GEN_SQUARE_EN
            .sq       (sq[i]),
`endif
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with three channels and DEFAULT_DIV=5.
// Square-output checks are compiled in when TICK_GEN_SQUARE_EN is defined.
module tb_tick_generator;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int WR_W   = 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              sync_clr;
    logic              wr_en;
    logic [WR_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] tick;
`ifdef TICK_GEN_SQUARE_EN
    logic [NUM_CH-1:0] sq;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    tick_generator #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
`ifdef TICK_GEN_SQUARE_EN
        .sq       (sq),
`endif
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across one edge and releases it mid-cycle; next edge is edge 1.
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; sync_clr = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        step();
        n_cmp++;
        if (tick !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_tick: got %b expected 000", tick);
        end
`ifdef TICK_GEN_SQUARE_EN
        n_cmp++;
        if (sq !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sq: got %b expected 000", sq);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_default();
        logic [NUM_CH-1:0] exp;
        test_reset();
        for (int c = 1; c <= 15; c++) begin
            step();
            exp = (c % 5 == 0) ? 3'b111 : 3'b000;
            n_cmp++;
            if (tick !== exp) begin
                n_fail++;
                $display("FAIL default_tick c=%0d: got %b expected %b", c, tick, exp);
            end
`ifdef TICK_GEN_SQUARE_EN
            exp = ((c / 5) % 2 == 1) ? 3'b111 : 3'b000;
            n_cmp++;
            if (sq !== exp) begin
                n_fail++;
                $display("FAIL default_sq c=%0d: got %b expected %b", c, sq, exp);
            end
`endif
        end
    endtask

    task automatic test_write();
        logic [NUM_CH-1:0] exp;
        test_reset();
        for (int c = 1; c <= 16; c++) begin
            wr_en  = (c == 7);
            wr_ch  = 2'd1;
            wr_div = 8'd3;
            step();
            exp = (c % 5 == 0) ? 3'b101 : 3'b000;
            if (c < 7)      exp[1] = (c == 5);
            else if (c > 7) exp[1] = ((c - 7) % 3 == 0);
            else            exp[1] = 1'b0;
            n_cmp++;
            if (tick !== exp) begin
                n_fail++;
                $display("FAIL write_tick c=%0d: got %b expected %b", c, tick, exp);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_div1_div0();
        test_reset();
        for (int c = 1; c <= 14; c++) begin
            wr_en  = (c == 1) || (c == 8);
            wr_ch  = 2'd2;
            wr_div = (c == 1) ? 8'd1 : 8'd0;
            step();
            if (c >= 2) begin
                n_cmp++;
                if (tick[2] !== (c >= 2 && c <= 7)) begin
                    n_fail++;
                    $display("FAIL div1_div0 c=%0d: got %b expected %b", c, tick[2], (c >= 2 && c <= 7));
                end
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_en_pause();
        logic exp;
        test_reset();
        for (int c = 1; c <= 17; c++) begin
            wr_en  = (c == 1);
            wr_ch  = 2'd0;
            wr_div = 8'd4;
            en     = !(c >= 6 && c <= 8);
            step();
            exp = (c == 5) || (c == 12) || (c == 16);
            n_cmp++;
            if (tick[0] !== exp) begin
                n_fail++;
                $display("FAIL en_pause c=%0d: got %b expected %b", c, tick[0], exp);
            end
        end
        wr_en = 1'b0;
        en    = 1'b1;
    endtask

    task automatic test_sync_clr();
        logic [NUM_CH-1:0] exp;
        test_reset();
        for (int c = 1; c <= 18; c++) begin
            wr_en    = (c == 1) || (c == 2) || (c == 12);
            wr_ch    = (c == 1) ? 2'd0 : (c == 2) ? 2'd1 : 2'd3;
            wr_div   = (c == 1) ? 8'd4 : (c == 2) ? 8'd6 : 8'd1;
            sync_clr = (c == 10);
            step();
            exp[0] = (c == 5) || (c == 9) || (c == 14) || (c == 18);
            exp[1] = (c == 8) || (c == 16);
            exp[2] = (c == 5) || (c == 15);
            n_cmp++;
            if (tick !== exp) begin
                n_fail++;
                $display("FAIL sync_clr c=%0d: got %b expected %b", c, tick, exp);
            end
        end
        wr_en    = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [NUM_CH-1:0] exp;
        test_reset();
        for (int c = 1; c <= 4; c++) begin
            wr_en  = (c == 1);
            wr_ch  = 2'd0;
            wr_div = 8'd3;
            step();
        end
        wr_en = 1'b0;
        n_cmp++;
        if (tick !== 3'b001) begin
            n_fail++;
            $display("FAIL async_pre: got %b expected 001", tick);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tick !== 3'b000) begin
            n_fail++;
            $display("FAIL async_tick: got %b expected 000", tick);
        end
`ifdef TICK_GEN_SQUARE_EN
        n_cmp++;
        if (sq !== 3'b000) begin
            n_fail++;
            $display("FAIL async_sq: got %b expected 000", sq);
        end
`endif
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp = (c == 5) ? 3'b111 : 3'b000;
            n_cmp++;
            if (tick !== exp) begin
                n_fail++;
                $display("FAIL async_after c=%0d: got %b expected %b", c, tick, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_write();
        test_div1_div0();
        test_en_pause();
        test_sync_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
